// File: rtl/ilog2_pkg.sv
// Shared definitions for the floor-log2 scheduler slice.
//   LOG2_W      : width of a floor-log2 result (0..31)
//   DATA_W      : operand width
//   ID_MAX_W    : tag id width, wide enough for up to 16 requesters
//   ilog2_tag_t : per-operation tag carried alongside the datapath
package ilog2_pkg;

    localparam int unsigned LOG2_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ID_MAX_W = 4;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                zero;
    } ilog2_tag_t;

endpackage

// File: rtl/ilog2_sched_if.sv
// Requester-side bus of ilog2_sched.
//   req_valid/req_data/hold : driven by the requesters (master)
//   req_ready               : one-hot grant back to the requesters
//   rsp_valid/rsp_log2/rsp_zero : one-cycle result strobe and payload
//   busy                    : at least one operation in flight
interface ilog2_sched_if
    import ilog2_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    logic                     hold;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          rsp_valid;
    logic [LOG2_W-1:0]        rsp_log2;
    logic                     rsp_zero;
    logic                     busy;

    modport master (
        output hold, req_valid, req_data,
        input  req_ready, rsp_valid, rsp_log2, rsp_zero, busy
    );

    modport slave (
        input  hold, req_valid, req_data,
        output req_ready, rsp_valid, rsp_log2, rsp_zero, busy
    );
endinterface

// File: rtl/ilog2_pipe.sv
// Fixed-latency 32-bit floor-log2 datapath.
//   clk, reset (async, active-high)
//   in_valid/in_data   : operand, accepted every cycle (no stalls)
//   out_valid/out_log2 : result LAT cycles later; log2 of 0 reads as 0
module ilog2_pipe
    import ilog2_pkg::*;
#(
    parameter int unsigned LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [LOG2_W-1:0] out_log2
);
    logic [LAT-1:0]             vld_q, vld_d;
    logic [LAT-1:0][LOG2_W-1:0] lg_q, lg_d;
    logic [LOG2_W-1:0]          enc;

    // Highest set bit wins; the encode sits in the first stage, later stages only delay.
    always_comb begin
        enc = '0;
        for (int unsigned b = 0; b < DATA_W; b++) begin
            if (in_data[b]) enc = LOG2_W'(b);
        end
    end

    always_comb begin
        vld_d    = vld_q;
        lg_d     = lg_q;
        vld_d[0] = in_valid;
        lg_d[0]  = enc;
        for (int unsigned k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            lg_d[k]  = lg_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            lg_q  <= '0;
        end else begin
            vld_q <= vld_d;
            lg_q  <= lg_d;
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_log2  = lg_q[LAT-1];
endmodule

// File: rtl/ilog2_sched.sv
// Round-robin scheduler sharing one ilog2_pipe among NREQ requesters.
//   clk, reset (async, active-high)
//   bus : ilog2_sched_if slave (hold, req_valid/req_data/req_ready,
//         rsp_valid/rsp_log2/rsp_zero, busy)
// Handshake in cycle t -> issue register t+1 -> pipe output t+1+LAT -> rsp at t+LAT+2.
module ilog2_sched
    import ilog2_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic         clk,
    input  logic         reset,
    ilog2_sched_if.slave bus
);
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [NREQ-1:0]       grant;
    logic                  gnt_any;
    logic [IDW-1:0]        gnt_id;
    ilog2_tag_t            iss_q, iss_d;
    logic [DATA_W-1:0]     iss_data_q, iss_data_d;
    ilog2_tag_t [LAT-1:0]  tag_q, tag_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [LOG2_W-1:0]     rsp_log2_q, rsp_log2_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  pipe_out_valid;
    logic [LOG2_W-1:0]     pipe_out_log2;
    logic                  tag_any;

    // Priority search starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (!bus.hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!gnt_any && bus.req_valid[idx[IDW-1:0]]) begin
                    gnt_any                = 1'b1;
                    gnt_id                 = idx[IDW-1:0];
                    grant[idx[IDW-1:0]]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;

        iss_data_d  = bus.req_data[32'(gnt_id)*DATA_W +: DATA_W];
        iss_d.valid = gnt_any;
        iss_d.id    = ID_MAX_W'(gnt_id);
        iss_d.zero  = (iss_data_d == '0);

        tag_d    = tag_q;
        tag_d[0] = iss_q;
        for (int unsigned k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];

        // Full-width id compare decodes the one-hot strobe without truncating the tag.
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_valid_d[i] = pipe_out_valid && (32'(tag_q[LAT-1].id) == i);
        end
        rsp_log2_d = rsp_log2_q;
        rsp_zero_d = rsp_zero_q;
        if (pipe_out_valid) begin
            rsp_log2_d = tag_q[LAT-1].zero ? '0 : pipe_out_log2;
            rsp_zero_d = tag_q[LAT-1].zero;
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int unsigned k = 0; k < LAT; k++) tag_any = tag_any | tag_q[k].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            iss_q       <= '0;
            iss_data_q  <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_log2_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            iss_q       <= iss_d;
            iss_data_q  <= iss_data_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_log2_q  <= rsp_log2_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    ilog2_pipe #(.LAT(LAT)) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iss_q.valid),
        .in_data   (iss_data_q),
        .out_valid (pipe_out_valid),
        .out_log2  (pipe_out_log2)
    );

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_log2  = rsp_log2_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.busy      = iss_q.valid | tag_any | (|rsp_valid_q);
endmodule

// File: tb/tb_ilog2_sched.sv
module tb_ilog2_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 4;

    typedef struct {
        int due;
        int id;
        int lg;
        bit z;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ilog2_sched_if #(.NREQ(NREQ)) bus ();

    ilog2_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // reference model state
    exp_t exq[$];
    int   mptr  = 0;
    int   mlog  = 0;
    bit   mzero = 1'b0;

    // stimulus state
    logic [NREQ-1:0] rv;
    logic [31:0]     d [NREQ];
    logic            hold_v;
    int              refill_pct = 0;
    bit              rand_hold  = 1'b0;

    // observations
    logic [NREQ-1:0] obs_ready, obs_rv;
    logic [4:0]      obs_log;
    logic            obs_zero, obs_busy;
    logic            prev_busy = 1'b0;
    int              obs_cyc, last_rsp_cyc, fall_cyc, rsp_total;
    int              rsp_cnt [NREQ];

    function automatic int flog2(logic [31:0] v);
        int r = 0;
        while (v > 32'd1) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(3))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'd1 << $urandom_range(31);
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        ntests++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic apply();
        bus.hold      = hold_v;
        bus.req_valid = rv;
        for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = d[i];
    endtask

    // One clock cycle: check at mid-cycle, update model at the edge, then drive.
    task automatic cycle();
        logic [NREQ-1:0] eg, erv;
        int   gi, i;
        exp_t e;
        #1;
        gi = -1;
        if (!hold_v) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (mptr + k) % NREQ;
                if (gi < 0 && rv[i]) gi = i;
            end
        end
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        erv = '0;
        chk("busy", 32'(bus.busy), 32'(exq.size() != 0));
        if (exq.size() != 0 && exq[0].due == cyc) begin
            e        = exq.pop_front();
            erv[e.id] = 1'b1;
            mlog     = e.z ? 0 : e.lg;
            mzero    = e.z;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(eg));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
        chk("rsp_log2",  32'(bus.rsp_log2),  32'(mlog));
        chk("rsp_zero",  32'(bus.rsp_zero),  32'(mzero));
        chk("pipe_vs_tag", 32'(dut.pipe_out_valid), 32'(dut.tag_q[LAT-1].valid));

        obs_ready = bus.req_ready;
        obs_rv    = bus.rsp_valid;
        obs_log   = bus.rsp_log2;
        obs_zero  = bus.rsp_zero;
        obs_busy  = bus.busy;
        obs_cyc   = cyc;
        if (obs_rv != '0) begin
            last_rsp_cyc = cyc;
            rsp_total++;
            for (int j = 0; j < NREQ; j++) if (obs_rv[j]) rsp_cnt[j]++;
        end
        if (prev_busy && !obs_busy) fall_cyc = cyc;
        prev_busy = obs_busy;

        @(posedge clk);
        if (gi >= 0) begin
            e.due = cyc + LAT + 2;
            e.id  = gi;
            e.lg  = flog2(d[gi]);
            e.z   = (d[gi] == 32'd0);
            exq.push_back(e);
            mptr = (gi + 1) % NREQ;
        end
        cyc++;
        #1;
        if (gi >= 0) rv[gi] = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!rv[j] && int'($urandom_range(99)) < refill_pct) begin
                rv[j] = 1'b1;
                d[j]  = rand_operand();
            end
        end
        if (rand_hold) hold_v = ($urandom_range(3) == 0);
        apply();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rv = '0;
        apply();
        #1 reset = 1'b1;
        #1;
        chk("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_async_busy",      32'(bus.busy),      32'd0);
        exq.delete();
        mptr  = 0;
        mlog  = 0;
        mzero = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset     = 1'b0;
        prev_busy = 1'b0;
    endtask

    task automatic issue_wait(input int id, input logic [31:0] data,
                              input int exp_log, input bit exp_zero, input string tag);
        bit seen = 1'b0;
        rv[id] = 1'b1;
        d[id]  = data;
        apply();
        for (int n = 0; n < LAT + 8; n++) begin
            cycle();
            if (obs_rv[id]) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_log2"}, 32'(obs_log), 32'(exp_log));
        chk({tag, "_zero"}, 32'(obs_zero), 32'(exp_zero));
    endtask

    initial begin
        int gcyc;
        bit seen;
        rv     = '0;
        hold_v = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            d[i]       = 32'd0;
            rsp_cnt[i] = 0;
        end
        rsp_total = 0;
        apply();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_log2",  32'(bus.rsp_log2),  32'd0);
        chk("rst_rsp_zero",  32'(bus.rsp_zero),  32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_ptr",       32'(dut.ptr_q),     32'd0);
        @(negedge clk);
        cyc++;
        repeat (2) cycle();

        // 1: single request, latency LAT+2
        rv[0] = 1'b1;
        d[0]  = 32'h0000_0100;
        apply();
        cycle();
        chk("t1_ready", 32'(obs_ready), 32'd1);
        gcyc = obs_cyc;
        seen = 1'b0;
        for (int n = 0; n < LAT + 8; n++) begin
            cycle();
            if (obs_rv != '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t1_seen",    32'(seen),            32'd1);
        chk("t1_latency", 32'(obs_cyc - gcyc),  32'(LAT + 2));
        chk("t1_rv",      32'(obs_rv),          32'd1);
        chk("t1_log2",    32'(obs_log),         32'd8);
        chk("t1_zero",    32'(obs_zero),        32'd0);
        repeat (3) cycle();

        // 2: all requesters valid for 16 cycles
        do_reset();
        for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
        refill_pct = 100;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b1;
            d[i]  = rand_operand();
        end
        apply();
        repeat (16) cycle();
        refill_pct = 0;
        rv = '0;
        apply();
        repeat (LAT + 4) cycle();
        for (int i = 0; i < NREQ; i++) chk($sformatf("t2_pulses%0d", i), 32'(rsp_cnt[i]), 32'd4);

        // 3: boundary operands
        issue_wait(1, 32'h0000_0000, 0, 1'b1, "t3_op0");
        issue_wait(1, 32'h0000_0001, 0, 1'b0, "t3_op1");
        issue_wait(1, 32'h0001_0000, 16, 1'b0, "t3_op2");
        issue_wait(1, 32'h8000_0000, 31, 1'b0, "t3_op3");
        issue_wait(1, 32'hFFFF_FFFF, 31, 1'b0, "t3_op4");

        // 4: pointer at 3, only req2 valid; then wrap 3 -> 0
        rv[2] = 1'b1; d[2] = 32'h10; apply(); cycle();
        chk("t4_ptr_a", 32'(dut.ptr_q), 32'd3);
        rv[2] = 1'b1; d[2] = 32'h20; apply(); cycle();
        chk("t4_ready", 32'(obs_ready), 32'b0100);
        chk("t4_ptr_b", 32'(dut.ptr_q), 32'd3);
        rv[3] = 1'b1; d[3] = 32'h40; apply(); cycle();
        chk("t4_wrap_ready", 32'(obs_ready), 32'b1000);
        chk("t4_ptr_wrap", 32'(dut.ptr_q), 32'd0);
        repeat (LAT + 4) cycle();

        // 5: hold mid-burst
        refill_pct = 100;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b1;
            d[i]  = rand_operand();
        end
        apply();
        repeat (3) cycle();
        hold_v = 1'b1;
        apply();
        rsp_total = 0;
        fall_cyc  = -1;
        repeat (LAT + 6) cycle();
        chk("t5_rsp_count", 32'(rsp_total), 32'd3);
        chk("t5_busy_fall", 32'(fall_cyc), 32'(last_rsp_cyc + 1));
        hold_v = 1'b0;
        refill_pct = 0;
        rv = '0;
        apply();
        repeat (2) cycle();

        // 6: reset with operations in flight
        refill_pct = 100;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b1;
            d[i]  = rand_operand();
        end
        apply();
        repeat (3) cycle();
        refill_pct = 0;
        do_reset();
        rsp_total = 0;
        repeat (LAT + 4) cycle();
        chk("t6_no_rsp", 32'(rsp_total), 32'd0);
        chk("t6_busy",   32'(obs_busy),  32'd0);
        rv = '1;
        apply();
        cycle();
        chk("t6_first_grant", 32'(obs_ready), 32'd1);
        rv = '0;
        apply();
        repeat (LAT + 4) cycle();

        // randomized traffic with random hold
        refill_pct = 40;
        rand_hold  = 1'b1;
        repeat (300) cycle();
        rand_hold  = 1'b0;
        hold_v     = 1'b0;
        refill_pct = 0;
        apply();
        repeat (2 * NREQ + LAT + 4) cycle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
